alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 137 +++++++++++++
 tb/tb_alu_operand_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand register with optional operand forwarding.
// Forwarding from the MEM and WB stages is compiled in when ALU_OPERAND_FWD_EN is defined.
module alu_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_shamt,
  input  logic [4:0]  in_rs_num,
  input  logic [4:0]  in_rt_num,
  input  logic [4:0]  in_rd_num,
  input  logic [3:0]  in_alu_ctrl,
  input  logic [1:0]  in_op_sel,
  input  logic        in_wb_en,
  input  logic        stall,
  input  logic        flush,
  input  logic        fwd_mem_en,
  input  logic        fwd_wb_en,
  input  logic [4:0]  fwd_mem_reg,
  input  logic [4:0]  fwd_wb_reg,
  input  logic [31:0] fwd_mem_val,
  input  logic [31:0] fwd_wb_val,
  output logic [31:0] alu_first,
  output logic [31:0] alu_second,
  output logic [3:0]  alu_control,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_wb_en,
  output logic [31:0] ex_store_data
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [4:0]  rd_num;
    logic [3:0]  alu_ctrl;
    logic [1:0]  op_sel;
    logic        wb_en;
  } stage_t;

  stage_t stage_d, stage_q;
  logic [31:0] op_a, op_b;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid    = in_valid;
      stage_d.rs_val   = in_rs_val;
      stage_d.rt_val   = in_rt_val;
      stage_d.imm      = in_imm;
      stage_d.shamt    = in_shamt;
      stage_d.rs_num   = in_rs_num;
      stage_d.rt_num   = in_rt_num;
      stage_d.rd_num   = in_rd_num;
      stage_d.alu_ctrl = in_alu_ctrl;
      stage_d.op_sel   = in_op_sel;
      stage_d.wb_en    = in_wb_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef ALU_OPERAND_FWD_EN
  // WB applied first so a matching MEM result overrides it; r0 is never forwarded.
  always_comb begin
    op_a = stage_q.rs_val;
    op_b = stage_q.rt_val;
    if (fwd_wb_en && (stage_q.rs_num != 5'd0) && (fwd_wb_reg == stage_q.rs_num)) begin
      op_a = fwd_wb_val;
    end
    if (fwd_mem_en && (stage_q.rs_num != 5'd0) && (fwd_mem_reg == stage_q.rs_num)) begin
      op_a = fwd_mem_val;
    end
    if (fwd_wb_en && (stage_q.rt_num != 5'd0) && (fwd_wb_reg == stage_q.rt_num)) begin
      op_b = fwd_wb_val;
    end
    if (fwd_mem_en && (stage_q.rt_num != 5'd0) && (fwd_mem_reg == stage_q.rt_num)) begin
      op_b = fwd_mem_val;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_en, fwd_wb_en, fwd_mem_reg, fwd_wb_reg, fwd_mem_val, fwd_wb_val};
  assign op_a = stage_q.rs_val;
  assign op_b = stage_q.rt_val;
`endif

  always_comb begin
    alu_first  = '0;
    alu_second = '0;
    unique case (stage_q.op_sel)
      2'b00: begin
        alu_first  = op_a;
        alu_second = op_b;
      end
      2'b01: begin
        alu_first  = op_a;
        alu_second = stage_q.imm;
      end
      2'b10: begin
        alu_first  = op_b;
        alu_second = {27'b0, stage_q.shamt};
      end
      2'b11: begin
        alu_first  = op_b;
        alu_second = {27'b0, op_a[4:0]};
      end
      default: ;
    endcase
    if (!stage_q.valid) begin
      alu_first  = '0;
      alu_second = '0;
    end
  end

  assign alu_control   = stage_q.valid ? stage_q.alu_ctrl : 4'd0;
  assign ex_valid      = stage_q.valid;
  assign ex_rd         = stage_q.rd_num;
  assign ex_wb_en      = stage_q.wb_en & stage_q.valid;
  assign ex_store_data = op_b;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against a behavioural model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_wb_en, stall, flush, fwd_mem_en, fwd_wb_en;
  logic [31:0] in_rs_val, in_rt_val, in_imm, fwd_mem_val, fwd_wb_val;
  logic [4:0]  in_shamt, in_rs_num, in_rt_num, in_rd_num, fwd_mem_reg, fwd_wb_reg;
  logic [3:0]  in_alu_ctrl;
  logic [1:0]  in_op_sel;
  logic [31:0] alu_first, alu_second, ex_store_data;
  logic [3:0]  alu_control;
  logic        ex_valid, ex_wb_en;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_rs_num(in_rs_num), .in_rt_num(in_rt_num),
    .in_rd_num(in_rd_num), .in_alu_ctrl(in_alu_ctrl), .in_op_sel(in_op_sel),
    .in_wb_en(in_wb_en), .stall(stall), .flush(flush), .fwd_mem_en(fwd_mem_en),
    .fwd_wb_en(fwd_wb_en), .fwd_mem_reg(fwd_mem_reg), .fwd_wb_reg(fwd_wb_reg),
    .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val), .alu_first(alu_first),
    .alu_second(alu_second), .alu_control(alu_control), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_wb_en(ex_wb_en), .ex_store_data(ex_store_data)
  );

  // Model: the instruction currently held by the stage.
  typedef struct {
    bit          valid;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  shamt, rs, rt, rd;
    logic [3:0]  ctrl;
    logic [1:0]  sel;
    bit          wb;
  } instr_t;

  instr_t held;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.rs_val = 0; b.rt_val = 0; b.imm = 0; b.shamt = 0;
    b.rs = 0; b.rt = 0; b.rd = 0; b.ctrl = 0; b.sel = 0; b.wb = 0;
    return b;
  endfunction

  function automatic logic [31:0] read_reg(logic [4:0] n, logic [31:0] file_val);
`ifdef ALU_OPERAND_FWD_EN
    if (n != 0 && fwd_mem_en && fwd_mem_reg == n) return fwd_mem_val;
    if (n != 0 && fwd_wb_en && fwd_wb_reg == n) return fwd_wb_val;
`endif
    return file_val;
  endfunction

  function automatic logic [106:0] expected_outs();
    logic [31:0] a, b, f, s;
    a = read_reg(held.rs, held.rs_val);
    b = read_reg(held.rt, held.rt_val);
    f = (held.sel[1]) ? b : a;
    case (held.sel)
      2'b00: s = b;
      2'b01: s = held.imm;
      2'b10: s = 32'(held.shamt);
      default: s = 32'(a % 32);
    endcase
    if (!held.valid) begin
      f = 0;
      s = 0;
    end
    return {f, s, held.valid ? held.ctrl : 4'd0, held.valid, held.rd,
            held.wb && held.valid, b};
  endfunction

  function automatic logic [106:0] dut_outs();
    return {alu_first, alu_second, alu_control, ex_valid, ex_rd, ex_wb_en, ex_store_data};
  endfunction

  // Advance one clock; the model samples the same inputs the DUT sees at the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst || flush) held = bubble();
    else if (!stall) begin
      held.valid = in_valid; held.rs_val = in_rs_val; held.rt_val = in_rt_val;
      held.imm = in_imm; held.shamt = in_shamt; held.rs = in_rs_num; held.rt = in_rt_num;
      held.rd = in_rd_num; held.ctrl = in_alu_ctrl; held.sel = in_op_sel; held.wb = in_wb_en;
    end
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; stall = 0; flush = 0; in_valid = 0; in_wb_en = 0;
    in_rs_val = 0; in_rt_val = 0; in_imm = 0; in_shamt = 0;
    in_rs_num = 0; in_rt_num = 0; in_rd_num = 0; in_alu_ctrl = 0; in_op_sel = 0;
    fwd_mem_en = 0; fwd_wb_en = 0; fwd_mem_reg = 0; fwd_wb_reg = 0;
    fwd_mem_val = 0; fwd_wb_val = 0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_wb_en = 1; stall = 1; flush = 1;
    in_rs_val = 32'h1234; in_rt_val = 32'h5678; in_imm = 32'h9; in_shamt = 5'd3;
    in_rs_num = 5'd1; in_rt_num = 5'd2; in_rd_num = 5'd3; in_alu_ctrl = 4'hA; in_op_sel = 2'b01;
    cycle();
    clear_inputs();
    #1;
    checks++;
    if (dut_outs() !== 107'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", dut_outs());
    end
  endtask

  task automatic test_imm_load();
    clear_inputs();
    in_valid = 1; in_rs_val = 32'd5; in_imm = 32'd7; in_op_sel = 2'b01; in_alu_ctrl = 4'b0000;
    cycle();
    checks++;
    if (alu_first !== 32'd5) begin
      errors++; $display("FAIL imm_first: got %h expected 5", alu_first);
    end
    checks++;
    if (alu_second !== 32'd7) begin
      errors++; $display("FAIL imm_second: got %h expected 7", alu_second);
    end
    checks++;
    if (alu_control !== 4'd0 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL imm_ctrl_valid: got %h/%b expected 0/1", alu_control, ex_valid);
    end
  endtask

  task automatic test_shift_select();
    clear_inputs();
    in_valid = 1; in_op_sel = 2'b10; in_rt_val = 32'h8000_0000; in_shamt = 5'd4;
    cycle();
    checks++;
    if (alu_first !== 32'h8000_0000 || alu_second !== 32'd4) begin
      errors++;
      $display("FAIL shift_imm: got %h/%h expected 80000000/4", alu_first, alu_second);
    end
    in_op_sel = 2'b11; in_rs_val = 32'hFFFF_FF23;
    cycle();
    checks++;
    if (alu_first !== 32'h8000_0000 || alu_second !== 32'd3) begin
      errors++;
      $display("FAIL shift_var: got %h/%h expected 80000000/3", alu_first, alu_second);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] want;
    clear_inputs();
    in_valid = 1; in_rs_num = 5'd8; in_rs_val = 32'h99;
    cycle();
    fwd_mem_en = 1; fwd_mem_reg = 5'd8; fwd_mem_val = 32'h11;
    fwd_wb_en = 1; fwd_wb_reg = 5'd8; fwd_wb_val = 32'h22;
    #1;
`ifdef ALU_OPERAND_FWD_EN
    want = 32'h11;
`else
    want = 32'h99;
`endif
    checks++;
    if (alu_first !== want) begin
      errors++; $display("FAIL fwd_mem_priority: got %h expected %h", alu_first, want);
    end
    fwd_mem_en = 0;
    #1;
`ifdef ALU_OPERAND_FWD_EN
    want = 32'h22;
`endif
    checks++;
    if (alu_first !== want) begin
      errors++; $display("FAIL fwd_wb: got %h expected %h", alu_first, want);
    end
    in_rs_num = 5'd0; in_rs_val = 32'h55; fwd_mem_en = 1; fwd_mem_reg = 5'd0;
    fwd_wb_reg = 5'd0;
    cycle();
    checks++;
    if (alu_first !== 32'h55) begin
      errors++; $display("FAIL fwd_r0: got %h expected 55", alu_first);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] want;
    clear_inputs();
    in_valid = 1; in_rs_num = 5'd3; in_rs_val = 32'hA; in_rt_num = 5'd4; in_rt_val = 32'hB;
    in_alu_ctrl = 4'd5; in_rd_num = 5'd7; in_wb_en = 1;
    cycle();
    stall = 1;
    in_valid = 0; in_rs_val = 32'hDEAD; in_alu_ctrl = 4'hF; in_rd_num = 5'd1; in_rs_num = 5'd9;
    for (int i = 0; i < 3; i++) begin
      fwd_mem_en = 1; fwd_mem_reg = 5'd3; fwd_mem_val = 32'h100 + i;
      cycle();
`ifdef ALU_OPERAND_FWD_EN
      want = 32'h100 + i;
`else
      want = 32'hA;
`endif
      checks++;
      if (alu_first !== want || alu_second !== 32'hB || alu_control !== 4'd5 ||
          ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_wb_en !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h/%h/%h/%b/%0d/%b expected %h/b/5/1/7/1", i,
                 alu_first, alu_second, alu_control, ex_valid, ex_rd, ex_wb_en, want);
      end
    end
    flush = 1;
    cycle();
    checks++;
    if (ex_valid !== 1'b0 || ex_wb_en !== 1'b0 || alu_control !== 4'd0) begin
      errors++;
      $display("FAIL stall_flush_bubble: got %b/%b/%h expected 0/0/0",
               ex_valid, ex_wb_en, alu_control);
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    in_valid = 1; in_rs_val = 32'h77; in_rt_val = 32'h66; in_rd_num = 5'd2; in_wb_en = 1;
    in_alu_ctrl = 4'd3;
    cycle();
    stall = 1;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    #1;
    checks++;
    if (dut_outs() !== 107'd0) begin
      errors++; $display("FAIL reset_mid_stall: got %h expected 0", dut_outs());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      in_valid = $urandom_range(0, 1); in_wb_en = $urandom_range(0, 1);
      in_rs_val = $urandom; in_rt_val = $urandom; in_imm = $urandom;
      in_shamt = 5'($urandom); in_rd_num = 5'($urandom);
      in_rs_num = 5'($urandom_range(0, 3)); in_rt_num = 5'($urandom_range(0, 3));
      in_alu_ctrl = 4'($urandom); in_op_sel = 2'($urandom);
      cycle();
      fwd_mem_en = $urandom_range(0, 1); fwd_wb_en = $urandom_range(0, 1);
      fwd_mem_reg = 5'($urandom_range(0, 3)); fwd_wb_reg = 5'($urandom_range(0, 3));
      fwd_mem_val = $urandom; fwd_wb_val = $urandom;
      #1;
      checks++;
      if (dut_outs() !== expected_outs()) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", n, dut_outs(), expected_outs());
      end
    end
  endtask

  initial begin
    held = bubble();
    clear_inputs();
    #2;
    test_reset();
    test_imm_load();
    test_shift_select();
    test_forwarding();
    test_stall_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
